enter_conditioner: RTL and testbench
====================================

Name: enter_conditioner

Overview:
- Front-end conditioner that sits directly upstream of the processor's Enter/Input pins.
- Synchronises and debounces the raw Enter pushbutton and the 8 data switches.
- Emits exactly one single-cycle Enter pulse per physical press, together with an 8-bit Input byte captured at that press and held stable between presses.
- Suppresses new presses while the processor reports Halt.

Parameters:
- DB_LIMIT, 50000, consecutive synchronised-stable cycles required to accept a press or release (legal range 1..2^CNT_W-1).
- CNT_W, 16, width of the debounce counter.

Ports:
- Clock  in  1  system clock; all flops on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- KeyRaw  in  1  raw Enter pushbutton, 1 = pressed; asynchronous to Clock.
- SwRaw  in  8  raw data switches; asynchronous to Clock.
- Halt  in  1  processor halted; while 1, new presses are ignored.
- Enter  out  1  one-cycle pulse per accepted press; drives processor Enter.
- Input  out  8  switch byte captured at the accepted press; drives processor Input.
- Busy  out  1  1 whenever the FSM is not in IDLE.
- PressCount  out  8  accepted-press counter, wraps 255->0.

Behaviour:
- Reset (Reset=0, asynchronous):
  - Synchroniser flops = 0, counter = 0, state = IDLE.
  - Enter = 0, Input = 8'h00, Busy = 0, PressCount = 0.
  - Takes effect mid-debounce or mid-pulse with no pulse emitted.
  - After release, the first press needs full synchronisation plus debounce.
- Synchronisation:
  - KeyRaw and each SwRaw bit pass through a 2-flop synchroniser.
  - key_s and sw_s are the second-stage outputs.
  - No logic is fed from the first stage.
- FSM states: IDLE, PRESS_DB, PULSE, HELD, REL_DB. All outputs are registered.
- IDLE:
  - cnt = 0.
  - key_s=1 and Halt=0 -> PRESS_DB with cnt=1.
  - key_s=1 and Halt=1 -> stay in IDLE.
- PRESS_DB:
  - key_s=0 -> IDLE, cnt=0 (glitch rejected, no pulse).
  - key_s=1 and cnt<DB_LIMIT -> cnt+1.
  - key_s=1 and cnt==DB_LIMIT -> PULSE. On that same edge: Input<=sw_s, Enter<=1, PressCount<=PressCount+1.
  - Halt rising during PRESS_DB -> IDLE, no pulse.
- PULSE:
  - Enter is 1 for exactly this one cycle.
  - Unconditional transition to HELD; Enter<=0.
- HELD:
  - Wait for key_s=0, then -> REL_DB with cnt=1.
  - Holding the key indefinitely produces no further pulses.
- REL_DB:
  - key_s=1 -> HELD (release bounce rejected).
  - key_s=0 and cnt<DB_LIMIT -> cnt+1.
  - key_s=0 and cnt==DB_LIMIT -> IDLE.
- Latency: with KeyRaw stable high from edge 0, Enter is high during the cycle after edge 2+DB_LIMIT, i.e. it is sampled high at edge 3+DB_LIMIT.
- DB_LIMIT=1:
  - Press accepted on the first PRESS_DB cycle where key_s=1.
  - Minimum press-to-press interval is 1 (IDLE) + 1 (PRESS_DB) + 1 (PULSE) + 1 (HELD) + 1 (REL_DB) cycles.
- Input stability:
  - Input changes only on the edge entering PULSE.
  - Switch changes at any other time are not visible on Input.
- Busy = (state != IDLE).
- Halt:
  - Sampled directly; the processor drives it synchronously.
  - Halt asserted in HELD or REL_DB does not abort the release sequence.
- Counter:
  - Saturates at DB_LIMIT; it never wraps inside the debounce states.

Test Plan:
1. DB_LIMIT=4; Reset low then high; SwRaw=8'hA5; KeyRaw 0->1 held 20 cycles, then 0 for 20 -> Enter is high for exactly one cycle at edge 7 after the raw rise; Input=8'hA5; PressCount=1; Busy returns to 0 after release debounce.
2. DB_LIMIT=4; KeyRaw bounces 1,0,1,0,1 at 1-cycle spacing, then stable 1 -> exactly one Enter pulse, timed DB_LIMIT cycles after the last synchronised rise; no pulse during the bounce.
3. DB_LIMIT=4; press accepted with SwRaw=8'h3C; SwRaw changed to 8'hFF while in HELD; release bounce 0,1,0 -> no second pulse; Input stays 8'h3C until the next accepted press, which then loads 8'hFF.
4. Halt=1; full clean press and release -> Enter never asserts; Input, PressCount and Busy stay unchanged. Halt=0 and press again -> one pulse.
5. Reset asserted while in PRESS_DB with cnt=3 -> Enter=0, Input=0, PressCount=0, Busy=0 immediately without a clock edge; key still held at reset release -> one pulse after full latency.
6. 256 clean presses with DB_LIMIT=1 -> 256 single-cycle pulses; PressCount wraps to 0; the last Input matches the last SwRaw.

Source files
------------

// File: rtl/enter_conditioner.sv
// Conditions the raw Enter pushbutton and data switches for the processor:
// synchronise, debounce, and emit one Enter pulse with a captured Input byte per press.
module enter_conditioner #(
  parameter int DB_LIMIT = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyRaw,
  input  logic [7:0] SwRaw,
  input  logic       Halt,
  output logic       Enter,
  output logic [7:0] Input,
  output logic       Busy,
  output logic [7:0] PressCount
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(DB_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_DB,
    S_PULSE,
    S_HELD,
    S_REL_DB
  } state_t;

  logic       r_key_meta;
  logic       r_key_s;
  logic [7:0] r_sw_meta;
  logic [7:0] r_sw_s;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_enter;
  logic [7:0]       r_input;
  logic             r_busy;
  logic [7:0]       r_press_count;

  // Only the second stage feeds logic; the first stage may go metastable.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
      r_sw_meta  <= 8'h00;
      r_sw_s     <= 8'h00;
    end else begin
      r_key_meta <= KeyRaw;
      r_key_s    <= r_key_meta;
      r_sw_meta  <= SwRaw;
      r_sw_s     <= r_sw_meta;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_enter       <= 1'b0;
      r_input       <= 8'h00;
      r_busy        <= 1'b0;
      r_press_count <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (r_key_s && !Halt) begin
            r_state <= S_PRESS_DB;
            r_cnt   <= CNT_ONE;
            r_busy  <= 1'b1;
          end
        end

        S_PRESS_DB: begin
          if (!r_key_s || Halt) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LIMIT) begin
            // Accepted press: capture the switches and fire on the same edge.
            r_state       <= S_PULSE;
            r_cnt         <= '0;
            r_enter       <= 1'b1;
            r_input       <= r_sw_s;
            r_press_count <= r_press_count + 8'd1;
          end else if (r_cnt < LIMIT) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_PULSE: begin
          r_state <= S_HELD;
          r_enter <= 1'b0;
        end

        S_HELD: begin
          if (!r_key_s) begin
            r_state <= S_REL_DB;
            r_cnt   <= CNT_ONE;
          end
        end

        S_REL_DB: begin
          // Halt is deliberately ignored here so a release always completes.
          if (r_key_s) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == LIMIT) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (r_cnt < LIMIT) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_enter <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Enter      = r_enter;
  assign Input      = r_input;
  assign Busy       = r_busy;
  assign PressCount = r_press_count;

endmodule

// File: tb/tb_enter_conditioner.sv
// Scoreboard bench for enter_conditioner: stimulus pushes expected pulses
// (Input, PressCount, cycle) and per-DUT monitors pop and compare on each Enter.
module tb_enter_conditioner;

  localparam int DB_A = 4;
  localparam int DB_B = 1;

  typedef struct {
    logic [7:0] din;
    logic [7:0] cnt;
    int         cyc;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       key_a, key_b, halt_a, halt_b;
  logic [7:0] sw_a, sw_b;
  logic       enter_a, enter_b, busy_a, busy_b;
  logic [7:0] in_a, in_b, cnt_a, cnt_b;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] exp_cnt_a = 8'd0;
  logic [7:0] last_sw_b = 8'd0;

  enter_conditioner #(.DB_LIMIT(DB_A), .CNT_W(16)) u_dut_a (
    .Clock(Clock), .Reset(Reset), .KeyRaw(key_a), .SwRaw(sw_a), .Halt(halt_a),
    .Enter(enter_a), .Input(in_a), .Busy(busy_a), .PressCount(cnt_a)
  );

  enter_conditioner #(.DB_LIMIT(DB_B), .CNT_W(16)) u_dut_b (
    .Clock(Clock), .Reset(Reset), .KeyRaw(key_b), .SwRaw(sw_b), .Halt(halt_b),
    .Enter(enter_b), .Input(in_b), .Busy(busy_b), .PressCount(cnt_b)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected pulse: Enter observed high at the negedge following edge c0+3+DB.
  task automatic press_a(input logic [7:0] sw, input bit expect_pulse);
    sw_a  = sw;
    key_a = 1'b1;
    if (expect_pulse) begin
      exp_cnt_a = exp_cnt_a + 8'd1;
      q_a.push_back('{din: sw, cnt: exp_cnt_a, cyc: cyc + 3 + DB_A});
    end
  endtask

  always @(negedge Clock) begin
    if (enter_a === 1'b1) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_enter", {31'd0, enter_a}, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("a_pulse_cycle", cyc, e_a.cyc);
        check("a_pulse_input", {24'd0, in_a}, {24'd0, e_a.din});
        check("a_pulse_count", {24'd0, cnt_a}, {24'd0, e_a.cnt});
      end
    end
  end

  always @(negedge Clock) begin
    if (enter_b === 1'b1) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_enter", {31'd0, enter_b}, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("b_pulse_cycle", cyc, e_b.cyc);
        check("b_pulse_input", {24'd0, in_b}, {24'd0, e_b.din});
        check("b_pulse_count", {24'd0, cnt_b}, {24'd0, e_b.cnt});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset  = 1'b0;
    key_a  = 1'b0; key_b  = 1'b0;
    halt_a = 1'b0; halt_b = 1'b0;
    sw_a   = 8'h00; sw_b  = 8'h00;
    #1;
    check("rst_enter", {31'd0, enter_a}, 32'd0);
    check("rst_input", {24'd0, in_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_count", {24'd0, cnt_a}, 32'd0);
    check("rst_b_count", {24'd0, cnt_b}, 32'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(negedge Clock);

    // Test 1: clean press with A5.
    press_a(8'hA5, 1'b1);
    repeat (10) @(negedge Clock);
    check("t1_busy_held", {31'd0, busy_a}, 32'd1);
    repeat (10) @(negedge Clock);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t1_busy_idle", {31'd0, busy_a}, 32'd0);
    check("t1_input", {24'd0, in_a}, 32'hA5);
    check("t1_count", {24'd0, cnt_a}, 32'd1);

    // Test 2: bouncing press; the pulse times from the last rise.
    sw_a  = 8'h11;
    key_a = 1'b1; @(negedge Clock);
    key_a = 1'b0; @(negedge Clock);
    key_a = 1'b1; @(negedge Clock);
    key_a = 1'b0; @(negedge Clock);
    press_a(8'h11, 1'b1);
    repeat (15) @(negedge Clock);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t2_count", {24'd0, cnt_a}, 32'd2);

    // Test 3: switch change while held, bouncy release, then a new press.
    press_a(8'h3C, 1'b1);
    repeat (12) @(negedge Clock);
    sw_a = 8'hFF;
    repeat (5) @(negedge Clock);
    check("t3_input_held", {24'd0, in_a}, 32'h3C);
    key_a = 1'b0; @(negedge Clock);
    key_a = 1'b1; @(negedge Clock);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t3_input_released", {24'd0, in_a}, 32'h3C);
    check("t3_busy_idle", {31'd0, busy_a}, 32'd0);
    check("t3_count", {24'd0, cnt_a}, 32'd3);
    press_a(8'hFF, 1'b1);
    repeat (12) @(negedge Clock);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t3_input_next", {24'd0, in_a}, 32'hFF);

    // Test 4: presses are ignored while halted.
    halt_a = 1'b1;
    press_a(8'h77, 1'b0);
    repeat (20) @(negedge Clock);
    check("t4_busy_halted", {31'd0, busy_a}, 32'd0);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t4_input", {24'd0, in_a}, 32'hFF);
    check("t4_count", {24'd0, cnt_a}, 32'd4);
    halt_a = 1'b0;
    press_a(8'h5A, 1'b1);
    repeat (12) @(negedge Clock);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t4_count_after", {24'd0, cnt_a}, 32'd5);

    // Test 5: asynchronous reset in PRESS_DB with cnt=3, key kept held.
    press_a(8'hC3, 1'b0);
    repeat (5) @(negedge Clock);
    check("t5_busy_before", {31'd0, busy_a}, 32'd1);
    #1 Reset = 1'b0;
    #1;
    check("t5_enter", {31'd0, enter_a}, 32'd0);
    check("t5_input", {24'd0, in_a}, 32'd0);
    check("t5_count", {24'd0, cnt_a}, 32'd0);
    check("t5_busy", {31'd0, busy_a}, 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    exp_cnt_a = 8'd0;
    press_a(8'hC3, 1'b1);
    repeat (12) @(negedge Clock);
    key_a = 1'b0;
    repeat (20) @(negedge Clock);
    check("t5_count_after", {24'd0, cnt_a}, 32'd1);

    // Test 6: 256 presses at DB_LIMIT=1; PressCount wraps to zero.
    for (int i = 0; i < 256; i++) begin
      last_sw_b = 8'(i * 37 + 11);
      sw_b  = last_sw_b;
      key_b = 1'b1;
      q_b.push_back('{din: last_sw_b, cnt: 8'(i + 1), cyc: cyc + 3 + DB_B});
      repeat (5) @(negedge Clock);
      key_b = 1'b0;
      repeat (5) @(negedge Clock);
    end
    repeat (10) @(negedge Clock);
    check("t6_count_wrap", {24'd0, cnt_b}, 32'd0);
    check("t6_last_input", {24'd0, in_b}, {24'd0, last_sw_b});

    check("a_missing_pulses", q_a.size(), 32'd0);
    check("b_missing_pulses", q_b.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
